// File: rtl/acc_requant_packer_pkg.sv
// Shared constants and FSM encoding for the accumulator requantise/pack stage.
// Build option: define RQ_ROUND_EN to round half up before the right shift.
`timescale 1ns/1ps
package acc_requant_packer_pkg;

    localparam int CH      = 64;    // channels per pixel word
    localparam int ACC_W   = 24;    // signed accumulator width per channel
    localparam int OUT_W   = 8;     // output width per channel
    localparam int NPIX    = 1024;  // pixels per feature map (32x32)
    localparam int ADDR_W  = 10;    // BRAM address width
    localparam int LANES   = 8;     // channels converted per cycle
    localparam int RD_LAT  = 1;     // accumulator BRAM read latency
    localparam int SHIFT_W = 5;

    localparam int STEPS   = CH / LANES;
    localparam int STEP_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int WAIT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        CONV,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/acc_requant_packer_rq_lane.sv
// One conversion lane: arithmetic right shift, optional round-half-up,
// ReLU and saturation of a signed accumulator value to a small unsigned code.
// Build option: RQ_ROUND_EN adds 2^(shift-1) before shifting when shift > 0.
`timescale 1ns/1ps
module rq_lane
    import acc_requant_packer_pkg::*;
(
    input  logic [ACC_W-1:0]   acc,
    input  logic [SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]   q
);

    // One extra bit of headroom keeps the rounding add from overflowing.
    localparam logic signed [ACC_W:0] Y_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);

    logic signed [ACC_W:0] v_ext;
    logic signed [ACC_W:0] v_rnd;
    logic signed [ACC_W:0] y;

    // Combinational shift / round / clamp of a single channel.
    always_comb begin
        v_ext = {acc[ACC_W-1], acc};
`ifdef RQ_ROUND_EN
        if (shift != '0) begin
            v_rnd = v_ext + ((ACC_W+1)'(1) << (shift - SHIFT_W'(1)));
        end else begin
            v_rnd = v_ext;
        end
`else
        v_rnd = v_ext;
`endif
        y = v_rnd >>> shift;
        if (y[ACC_W]) begin
            q = '0;
        end else if (y > Y_MAX) begin
            q = Y_MAX[OUT_W-1:0];
        end else begin
            q = y[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/acc_requant_packer.sv
// Walks every pixel word of the accumulator BRAM, requantises each channel
// (shift, ReLU, saturate) LANES channels per cycle, and writes the packed
// result to the next layer's input BRAM at the same pixel address.
// Build option: RQ_ROUND_EN selects round-half-up instead of truncation.
`timescale 1ns/1ps
module acc_requant_packer
    import acc_requant_packer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,   // asynchronous, active-high
    input  logic                  start,
    input  logic [SHIFT_W-1:0]    shift,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [CH*ACC_W-1:0]   rd_data,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [CH*OUT_W-1:0]   wr_data,
    output logic                  busy,
    output logic                  done
);

    state_t               state_reg;
    logic [ADDR_W-1:0]    pix_reg;
    logic [STEP_W-1:0]    step_reg;
    logic [WAIT_W-1:0]    wait_reg;
    logic [SHIFT_W-1:0]   shift_q_reg;
    logic [CH*ACC_W-1:0]  hold_reg;
    logic [CH*OUT_W-1:0]  pack_reg;
    logic [CH*OUT_W-1:0]  pack_next;

    logic [ACC_W-1:0]     lane_acc [LANES];
    logic [OUT_W-1:0]     lane_q   [LANES];

    // Each lane handles channel step*LANES+gi of the held pixel word.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_acc[gi] = hold_reg[(int'(step_reg) * LANES + gi) * ACC_W +: ACC_W];

            rq_lane u_lane (
                .acc   (lane_acc[gi]),
                .shift (shift_q_reg),
                .q     (lane_q[gi])
            );
        end
    endgenerate

    // Merge the current step's lane outputs into the pack word; the merged
    // value feeds wr_data directly on the last step so WRITE needs no extra cycle.
    always_comb begin
        pack_next = pack_reg;
        for (int i = 0; i < LANES; i++) begin
            pack_next[(int'(step_reg) * LANES + i) * OUT_W +: OUT_W] = lane_q[i];
        end
    end

    // Pass sequencer with registered BRAM strobes and status outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg   <= IDLE;
            pix_reg     <= '0;
            step_reg    <= '0;
            wait_reg    <= '0;
            shift_q_reg <= '0;
            hold_reg    <= '0;
            pack_reg    <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_q_reg <= shift;
                        pix_reg     <= '0;
                        busy        <= 1'b1;
                        rd_en       <= 1'b1;
                        rd_addr     <= '0;
                        state_reg   <= READ;
                    end
                end
                READ: begin
                    rd_en     <= 1'b0;
                    wait_reg  <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (wait_reg == WAIT_W'(RD_LAT - 1)) begin
                        hold_reg  <= rd_data;
                        step_reg  <= '0;
                        state_reg <= CONV;
                    end else begin
                        wait_reg <= wait_reg + 1'b1;
                    end
                end
                CONV: begin
                    pack_reg <= pack_next;
                    if (step_reg == STEP_W'(STEPS - 1)) begin
                        wr_en     <= 1'b1;
                        wr_addr   <= pix_reg;
                        wr_data   <= pack_next;
                        state_reg <= WRITE;
                    end else begin
                        step_reg <= step_reg + 1'b1;
                    end
                end
                WRITE: begin
                    wr_en <= 1'b0;
                    if (pix_reg == ADDR_W'(NPIX - 1)) begin
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        pix_reg   <= pix_reg + 1'b1;
                        rd_en     <= 1'b1;
                        rd_addr   <= pix_reg + 1'b1;
                        state_reg <= READ;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_requant_packer.sv
// Self-checking bench for acc_requant_packer: BRAM models, write monitor and
// an integer-arithmetic reference of the per-channel requantisation.
`timescale 1ns/1ps
module tb_acc_requant_packer;
    import acc_requant_packer_pkg::*;

    localparam int PASS_CYC = NPIX * (2 + RD_LAT + STEPS) + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic [SHIFT_W-1:0]   shift = '0;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [CH*ACC_W-1:0]  rd_data = '0;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [CH*OUT_W-1:0]  wr_data;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int errors = 0;

    logic [CH*ACC_W-1:0] acc_mem [NPIX];
    logic [ADDR_W-1:0]   ra_q [$];
    logic [ADDR_W-1:0]   wa_q [$];
    logic [CH*OUT_W-1:0] wd_q [$];

    acc_requant_packer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .shift   (shift),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Accumulator BRAM, one cycle registered read.
    always @(posedge clk) begin
        if (rd_en) rd_data <= acc_mem[rd_addr];
    end

    // Record read addresses and writes, sampled mid-cycle.
    always @(negedge clk) begin
        if (rd_en) ra_q.push_back(rd_addr);
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: real integer arithmetic on the signed channel value.
    function automatic logic [OUT_W-1:0] ref_chan(input logic [ACC_W-1:0] a, input int s);
        longint y;
        y = longint'($signed(a));
`ifdef RQ_ROUND_EN
        if (s > 0) y = y + (longint'(1) << (s - 1));
`endif
        y = y >>> s;
        if (y < 0) return '0;
        if (y > 127) return 8'd127;
        return 8'(y);
    endfunction

    function automatic logic [CH*OUT_W-1:0] ref_word(input logic [CH*ACC_W-1:0] w, input int s);
        logic [CH*OUT_W-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r[c*OUT_W +: OUT_W] = ref_chan(w[c*ACC_W +: ACC_W], s);
        return r;
    endfunction

    task automatic fill_random();
        int sv;
        for (int a = 0; a < NPIX; a++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    sv = int'($urandom_range(0, 1200)) - 600;
                    acc_mem[a][c*ACC_W +: ACC_W] = 24'(sv);
                end else begin
                    acc_mem[a][c*ACC_W +: ACC_W] = 24'($urandom);
                end
            end
        end
    endtask

    // Drives one pass; optionally pulses a second start with another shift.
    task automatic run_pass(input logic [SHIFT_W-1:0] s, input int second_at,
                            input logic [SHIFT_W-1:0] s2,
                            output int n_done, output int busy_cyc, output bit tmo);
        int cyc;
        ra_q.delete(); wa_q.delete(); wd_q.delete();
        n_done = 0; busy_cyc = 0; cyc = 0;
        @(negedge clk);
        start = 1'b1; shift = s;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy) busy_cyc++;
            if (done) n_done++;
            if (cyc == second_at) begin start = 1'b1; shift = s2; end
        end while (busy && cyc < PASS_CYC + 100);
        tmo = busy;
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b, expected 0", rd_en); end
        checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0d, expected 0", rd_addr); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b, expected 0", wr_en); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0d, expected 0", wr_addr); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got nonzero, expected 0"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, expected 0", busy); end
        $display("test_reset: outputs idle after reset");
    endtask

    task automatic test_const5();
        int nd, bc, bad;
        bit tmo;
        logic [CH*OUT_W-1:0] exp_w;
        exp_w = {CH{8'h05}};
        for (int a = 0; a < NPIX; a++) acc_mem[a] = {CH{24'd5}};
        run_pass(5'd0, 0, 5'd0, nd, bc, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL const5_timeout: got busy stuck, expected end of pass"); end
        checks++; if (wa_q.size() !== NPIX) begin errors++; $display("FAIL const5_nwrites: got %0d, expected %0d", wa_q.size(), NPIX); end
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++) if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_w) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL const5_data: got %0d bad writes, expected 0", bad); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL const5_done: got %0d pulses, expected 1", nd); end
        checks++; if (bc !== PASS_CYC) begin errors++; $display("FAIL const5_busy: got %0d cycles, expected %0d", bc, PASS_CYC); end
        $display("test_const5: writes=%0d done=%0d busy_cycles=%0d", wa_q.size(), nd, bc);
    endtask

    task automatic test_specials_second_start();
        int nd, bc, bad;
        bit tmo;
        logic [OUT_W-1:0] exp_b0;
        logic [CH*OUT_W-1:0] w;
        fill_random();
        acc_mem[0][0 +: ACC_W]       = 24'h000180;
        acc_mem[1][3*ACC_W +: ACC_W] = 24'hFFFFFB;
        acc_mem[1][7*ACC_W +: ACC_W] = 24'h7FFFFF;
`ifdef RQ_ROUND_EN
        exp_b0 = 8'h02;
`else
        exp_b0 = 8'h01;
`endif
        run_pass(5'd8, 100, 5'd4, nd, bc, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL spec_timeout: got busy stuck, expected end of pass"); end
        checks++; if (wa_q.size() !== NPIX) begin errors++; $display("FAIL spec_nwrites: got %0d, expected %0d", wa_q.size(), NPIX); end
        if (wa_q.size() >= 2) begin
            w = wd_q[0];
            checks++; if (w[7:0] !== exp_b0) begin errors++; $display("FAIL spec_round_byte0: got %02h, expected %02h", w[7:0], exp_b0); end
            w = wd_q[1];
            checks++; if (w[31:24] !== 8'h00) begin errors++; $display("FAIL spec_relu_byte3: got %02h, expected 00", w[31:24]); end
            checks++; if (w[63:56] !== 8'h7F) begin errors++; $display("FAIL spec_sat_byte7: got %02h, expected 7f", w[63:56]); end
        end
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== ref_word(acc_mem[i], 8)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL spec_model: got %0d bad writes, expected 0", bad); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL spec_done: got %0d pulses, expected 1", nd); end
        checks++; if (bc !== PASS_CYC) begin errors++; $display("FAIL spec_busy: got %0d cycles, expected %0d", bc, PASS_CYC); end
        $display("test_specials_second_start: writes=%0d done=%0d busy_cycles=%0d", wa_q.size(), nd, bc);
    endtask

    task automatic test_addr_pattern();
        int nd, bc, bad, badra;
        bit tmo;
        logic [CH*OUT_W-1:0] w;
        for (int a = 0; a < NPIX; a++) acc_mem[a] = {CH{24'(a)}};
        run_pass(5'd0, 0, 5'd0, nd, bc, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL addr_timeout: got busy stuck, expected end of pass"); end
        checks++; if (wa_q.size() !== NPIX) begin errors++; $display("FAIL addr_nwrites: got %0d, expected %0d", wa_q.size(), NPIX); end
        checks++; if (ra_q.size() !== wa_q.size()) begin errors++; $display("FAIL addr_nreads: got %0d, expected %0d", ra_q.size(), wa_q.size()); end
        bad = 0; badra = 0;
        for (int i = 0; i < wa_q.size(); i++) begin
            if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== ref_word(acc_mem[i], 0)) bad++;
            if (i < ra_q.size() && ra_q[i] !== wa_q[i]) badra++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL addr_model: got %0d bad writes, expected 0", bad); end
        checks++; if (badra !== 0) begin errors++; $display("FAIL addr_rd_wr: got %0d mismatched addresses, expected 0", badra); end
        if (wa_q.size() > 200) begin
            w = wd_q[100];
            checks++; if (w[7:0] !== 8'h64) begin errors++; $display("FAIL addr_byte_100: got %02h, expected 64", w[7:0]); end
            w = wd_q[200];
            checks++; if (w[511:504] !== 8'h7F) begin errors++; $display("FAIL addr_sat_200: got %02h, expected 7f", w[511:504]); end
        end
        checks++; if (nd !== 1) begin errors++; $display("FAIL addr_done: got %0d pulses, expected 1", nd); end
        $display("test_addr_pattern: writes=%0d done=%0d", wa_q.size(), nd);
    endtask

    task automatic test_reset_midpass();
        int nd, bc, bad, cyc, n_done_after;
        bit tmo, found;
        logic [SHIFT_W-1:0] s;
        fill_random();
        @(negedge clk);
        start = 1'b1; shift = 5'd3;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0; cyc = 0;
        while (!found && cyc < 2000) begin
            if (rd_en && rd_addr == ADDR_W'(10)) found = 1'b1;
            else begin @(negedge clk); cyc++; end
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_find_pix10: got no read of 10, expected one"); end
        repeat (3) @(negedge clk);   // WAIT, CONV step 0, CONV step 1
        wa_q.delete();
        rst_n = 1'b1;
        #1;
        checks++; if ({rd_en, wr_en, busy, done} !== 4'b0) begin errors++; $display("FAIL mid_async_strobes: got %b, expected 0000", {rd_en, wr_en, busy, done}); end
        @(posedge clk); #1;
        checks++; if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin errors++; $display("FAIL mid_edge_regs: got rd_addr=%0d wr_addr=%0d, expected zeros", rd_addr, wr_addr); end
        @(negedge clk);
        rst_n = 1'b0;
        n_done_after = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) n_done_after++;
        end
        checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL mid_no_write: got %0d writes, expected 0", wa_q.size()); end
        checks++; if (n_done_after !== 0) begin errors++; $display("FAIL mid_no_resume: got %0d busy/done cycles, expected 0", n_done_after); end
        s = 5'($urandom_range(0, 12));
        run_pass(s, 0, 5'd0, nd, bc, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL restart_timeout: got busy stuck, expected end of pass"); end
        checks++; if (wa_q.size() == 0 || wa_q[0] !== '0) begin errors++; $display("FAIL restart_addr0: got %0d writes, expected first at 0", wa_q.size()); end
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== ref_word(acc_mem[i], int'(s))) bad++;
        checks++; if (bad !== 0 || wa_q.size() !== NPIX) begin errors++; $display("FAIL restart_model: got %0d bad of %0d writes, expected 0 of %0d", bad, wa_q.size(), NPIX); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL restart_done: got %0d pulses, expected 1", nd); end
        $display("test_reset_midpass: shift=%0d writes=%0d done=%0d", s, wa_q.size(), nd);
    endtask

    initial begin
        test_reset();
        test_const5();
        test_specials_second_start();
        test_addr_pattern();
        test_reset_midpass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
